// File: rtl/hex_sseg_monitor_if.sv
// rtl/hex_sseg_monitor_if.sv - bus bundle between a 4-digit seven-segment driver and its monitor

interface hex_sseg_monitor_if;

  // Observed multiplexed display bus (active-low enables and segments)
  logic [3:0] an;
  logic [7:0] sseg;

  // Error clear request
  logic       clr_err;

  // Decoded display state
  logic [3:0] hex0;
  logic [3:0] hex1;
  logic [3:0] hex2;
  logic [3:0] hex3;
  logic [3:0] dp_out;
  logic [3:0] seg_err;
  logic       frame_tick;
  logic       blank;

  // Side that drives the display bus and consumes the decoded state
  modport master (
    output an,
    output sseg,
    output clr_err,
    input  hex0,
    input  hex1,
    input  hex2,
    input  hex3,
    input  dp_out,
    input  seg_err,
    input  frame_tick,
    input  blank
  );

  // Monitor side
  modport slave (
    input  an,
    input  sseg,
    input  clr_err,
    output hex0,
    output hex1,
    output hex2,
    output hex3,
    output dp_out,
    output seg_err,
    output frame_tick,
    output blank
  );

endinterface

// File: rtl/hex_sseg_monitor.sv
// rtl/hex_sseg_monitor.sv - recovers hex digits from a multiplexed seven-segment display bus

module hex_sseg_monitor #(
  parameter int unsigned STABLE = 16
) (
  input logic                 clk,
  input logic                 reset,
  hex_sseg_monitor_if.slave   mon
);

  // Counter is 8 bits wide so any STABLE up to 255 fits without wrapping
  localparam logic [7:0] STABLE_C = 8'(STABLE);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COUNT  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  // Sample stage: every decision below works on these registered copies
  logic [3:0] s_an;
  logic [7:0] s_seg;

  // Reference sample the current stability run is measured against
  logic [3:0] ref_an;
  logic [7:0] ref_seg;

  state_t     state;
  state_t     state_next;
  logic [7:0] cnt;
  logic [7:0] cnt_next;
  logic       load_ref;
  logic       accept;

  logic       valid;
  logic       same;
  logic [3:0] dig_sel;

  logic       dec_ok;
  logic [3:0] dec_hex;

  logic [3:0] hex_q [4];
  logic [3:0] dp_q;
  logic [3:0] err_q;
  logic [3:0] seen;
  logic [3:0] seen_next;
  logic [3:0] err_set;
  logic       tick_q;

  // Glyph table, segments a..g on bits 6..0, 0 = lit; returns {match, value}
  function automatic logic [4:0] decode(input logic [6:0] p);
    case (p)
      7'b0000001: decode = {1'b1, 4'h0};
      7'b1001111: decode = {1'b1, 4'h1};
      7'b0010010: decode = {1'b1, 4'h2};
      7'b0000110: decode = {1'b1, 4'h3};
      7'b1001100: decode = {1'b1, 4'h4};
      7'b0100100: decode = {1'b1, 4'h5};
      7'b0100000: decode = {1'b1, 4'h6};
      7'b0001111: decode = {1'b1, 4'h7};
      7'b0000000: decode = {1'b1, 4'h8};
      7'b0000100: decode = {1'b1, 4'h9};
      7'b0001000: decode = {1'b1, 4'hA};
      7'b1100000: decode = {1'b1, 4'hB};
      7'b0110001: decode = {1'b1, 4'hC};
      7'b1000010: decode = {1'b1, 4'hD};
      7'b0110000: decode = {1'b1, 4'hE};
      7'b0111000: decode = {1'b1, 4'hF};
      default:    decode = {1'b0, 4'h0};
    endcase
  endfunction

  // Register the raw display bus once; idle value is "nothing enabled, nothing lit"
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s_an  <= 4'b1111;
      s_seg <= 8'hFF;
    end else begin
      s_an  <= mon.an;
      s_seg <= mon.sseg;
    end
  end

  // Sample qualification: exactly one enable low, and identity with the reference
  always_comb begin
    dig_sel = ~s_an;
    valid   = (dig_sel != 4'b0000) && ((dig_sel & (dig_sel - 4'd1)) == 4'b0000);
    same    = (s_an == ref_an) && (s_seg == ref_seg);
    {dec_ok, dec_hex} = decode(s_seg[6:0]);
  end

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next state, stability counter update and acceptance strobe
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    load_ref   = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (valid) begin
          cnt_next   = 8'd1;
          load_ref   = 1'b1;
          state_next = COUNT;
        end else begin
          cnt_next   = 8'd0;
        end
      end
      COUNT: begin
        if (!valid) begin
          cnt_next   = 8'd0;
          state_next = IDLE;
        end else if (same) begin
          // The edge that brings the count to STABLE is also the acceptance edge
          if (cnt >= STABLE_C - 8'd1) begin
            cnt_next   = STABLE_C;
            accept     = 1'b1;
            state_next = LOCKED;
          end else begin
            cnt_next   = cnt + 8'd1;
          end
        end else begin
          cnt_next   = 8'd1;
          load_ref   = 1'b1;
        end
      end
      LOCKED: begin
        if (!valid) begin
          cnt_next   = 8'd0;
          state_next = IDLE;
        end else if (!same) begin
          cnt_next   = 8'd1;
          load_ref   = 1'b1;
          state_next = COUNT;
        end
        // An unchanged sample keeps the saturated count and is not re-accepted
      end
      default: begin
        cnt_next   = 8'd0;
        state_next = IDLE;
      end
    endcase
  end

  // Stability counter and reference sample
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt     <= 8'd0;
      ref_an  <= 4'b1111;
      ref_seg <= 8'hFF;
    end else begin
      cnt <= cnt_next;
      if (load_ref) begin
        ref_an  <= s_an;
        ref_seg <= s_seg;
      end
    end
  end

  // Error bits raised by this cycle's acceptance, and the frame mask including it
  always_comb begin
    err_set   = (accept && !dec_ok) ? dig_sel : 4'b0000;
    seen_next = seen | (accept ? dig_sel : 4'b0000);
  end

  // Per-digit value and decimal point capture on acceptance
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        hex_q[i] <= 4'h0;
      end
      dp_q <= 4'b0000;
    end else if (accept) begin
      for (int i = 0; i < 4; i++) begin
        if (dig_sel[i]) begin
          dp_q[i] <= ~s_seg[7];
          // An unknown glyph leaves the last good value in place
          if (dec_ok) begin
            hex_q[i] <= dec_hex;
          end
        end
      end
    end
  end

  // Sticky glyph errors; a new error in the clearing cycle survives the clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q <= 4'b0000;
    end else begin
      err_q <= (mon.clr_err ? 4'b0000 : err_q) | err_set;
    end
  end

  // Frame tracking: pulse once every digit has been accepted, then start over
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seen   <= 4'b0000;
      tick_q <= 1'b0;
    end else begin
      tick_q <= (seen_next == 4'b1111);
      seen   <= (seen_next == 4'b1111) ? 4'b0000 : seen_next;
    end
  end

  assign mon.hex0       = hex_q[0];
  assign mon.hex1       = hex_q[1];
  assign mon.hex2       = hex_q[2];
  assign mon.hex3       = hex_q[3];
  assign mon.dp_out     = dp_q;
  assign mon.seg_err    = err_q;
  assign mon.frame_tick = tick_q;
  assign mon.blank      = (s_an == 4'b1111);

endmodule

// File: tb/tb_hex_sseg_monitor.sv
// tb/tb_hex_sseg_monitor.sv - directed self-checking bench for hex_sseg_monitor

module tb_hex_sseg_monitor;

  localparam int unsigned STABLE = 4;

  logic clk = 1'b0;
  logic reset;

  hex_sseg_monitor_if mon();

  hex_sseg_monitor #(.STABLE(STABLE)) dut (
    .clk   (clk),
    .reset (reset),
    .mon   (mon)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int tick_cnt = 0;

  // Count frame_tick pulses half a cycle after the edge that produced them
  always @(negedge clk) begin
    if (mon.frame_tick === 1'b1) tick_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic hold(input logic [3:0] a, input logic [7:0] s, input int n);
    mon.an   = a;
    mon.sseg = s;
    step(n);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_hex0"},  32'(mon.hex0), 32'h0);
    check({tag, "_hex1"},  32'(mon.hex1), 32'h0);
    check({tag, "_hex2"},  32'(mon.hex2), 32'h0);
    check({tag, "_hex3"},  32'(mon.hex3), 32'h0);
    check({tag, "_dp"},    32'(mon.dp_out), 32'h0);
    check({tag, "_err"},   32'(mon.seg_err), 32'h0);
    check({tag, "_tick"},  32'(mon.frame_tick), 32'h0);
    check({tag, "_blank"}, 32'(mon.blank), 32'h1);
  endtask

  initial begin
    reset       = 1'b1;
    mon.an      = 4'b1111;
    mon.sseg    = 8'hFF;
    mon.clr_err = 1'b0;
    step(3);
    check_reset_values("rst");
    #2 reset = 1'b0;
    step(2);

    // Pattern held one cycle short of STABLE, then blanked: nothing accepted
    hold(4'b1110, 8'b1_0000110, 3);
    hold(4'b1111, 8'hFF, 4);
    check("short_hex0", 32'(mon.hex0), 32'h0);
    check("short_err",  32'(mon.seg_err), 32'h0);
    check("short_tick", 32'(tick_cnt), 32'd0);

    // 'A' with dp lit on digit 1: value appears exactly STABLE edges after first sample
    hold(4'b1101, 8'b0_0001000, 4);
    check("lat_before", 32'(mon.hex1), 32'h0);
    step(1);
    check("lat_hex1",   32'(mon.hex1), 32'hA);
    check("lat_dp",     32'(mon.dp_out), 32'b0010);
    step(1);

    // Full frame 1,2,3,4 with dp dark; digit 1 is a re-acceptance
    hold(4'b1110, 8'hCF, 5);
    hold(4'b1101, 8'h92, 5);
    hold(4'b1011, 8'h86, 5);
    check("frame_early_tick", 32'(tick_cnt), 32'd0);
    hold(4'b0111, 8'hCC, 5);
    check("frame_tick_pulse", 32'(mon.frame_tick), 32'h1);
    step(1);
    check("frame_tick_drop", 32'(mon.frame_tick), 32'h0);
    check("frame_hex0", 32'(mon.hex0), 32'h1);
    check("frame_hex1", 32'(mon.hex1), 32'h2);
    check("frame_hex2", 32'(mon.hex2), 32'h3);
    check("frame_hex3", 32'(mon.hex3), 32'h4);
    check("frame_dp",   32'(mon.dp_out), 32'b0000);
    check("frame_ticks", 32'(tick_cnt), 32'd1);

    // Digit 0 again (5): fresh frame begins, no tick
    hold(4'b1110, 8'b1_0100100, 6);
    check("rep_hex0",  32'(mon.hex0), 32'h5);
    check("rep_ticks", 32'(tick_cnt), 32'd1);

    // Unknown glyph on digit 2: error set, value kept
    hold(4'b1011, 8'b1_1111110, 5);
    check("err_set",  32'(mon.seg_err), 32'b0100);
    check("err_hex2", 32'(mon.hex2), 32'h3);
    mon.clr_err = 1'b1;
    step(1);
    mon.clr_err = 1'b0;
    check("err_clr",  32'(mon.seg_err), 32'b0000);

    // Error on digit 3, then clear coincident with a new error on digit 2
    hold(4'b0111, 8'hFE, 5);
    check("err3_set",  32'(mon.seg_err), 32'b1000);
    check("err3_hex3", 32'(mon.hex3), 32'h4);
    hold(4'b1011, 8'hFF, 4);
    mon.clr_err = 1'b1;
    step(1);
    mon.clr_err = 1'b0;
    check("err_set_wins", 32'(mon.seg_err), 32'b0100);
    step(1);
    check("err_ticks", 32'(tick_cnt), 32'd1);

    // Two enables low for 20 cycles: never valid, display not blank
    hold(4'b1100, 8'hCF, 20);
    check("multi_blank", 32'(mon.blank), 32'h0);
    check("multi_hex0",  32'(mon.hex0), 32'h5);
    check("multi_hex2",  32'(mon.hex2), 32'h3);
    check("multi_err",   32'(mon.seg_err), 32'b0100);
    check("multi_ticks", 32'(tick_cnt), 32'd1);
    hold(4'b1111, 8'hFF, 1);
    check("blank_high", 32'(mon.blank), 32'h1);

    // Reset two counts into a valid run, then a full run is needed again
    hold(4'b1110, 8'h92, 3);
    reset = 1'b1;
    #1;
    check_reset_values("midrst");
    #2 reset = 1'b0;
    step(4);
    check("midrst_partial", 32'(mon.hex0), 32'h0);
    step(1);
    check("midrst_full", 32'(mon.hex0), 32'h2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
